// File: rtl/debounce_pulser_pkg.sv
// Shared definitions for the input-conditioning blocks: the 2-bit
// debounce state encodings and a parameter-range helper.
package debounce_pulser_pkg;

   // Fixed encodings, so other input-conditioning blocks decode the same way.
   localparam logic [1:0] ST_LOW     = 2'd0;
   localparam logic [1:0] ST_TO_HIGH = 2'd1;
   localparam logic [1:0] ST_HIGH    = 2'd2;
   localparam logic [1:0] ST_TO_LOW  = 2'd3;

   typedef enum logic [1:0] {
      LOW     = ST_LOW,
      TO_HIGH = ST_TO_HIGH,
      HIGH    = ST_HIGH,
      TO_LOW  = ST_TO_LOW
   } state_t;

   // True when a settle count fits the counter: 1 .. 2**size.
   function automatic bit settle_ok(input int size, input int settle);
      return (settle >= 1) && (settle <= (1 << size));
   endfunction

endpackage

// File: rtl/debounce_pulser_input_sync.sv
// Two-flop synchronizer for an asynchronous pin; clears to 0 on reset.
module input_sync (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta;

   // Shift the raw pin through two flops to settle metastability.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q_o  <= 1'b0;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/debounce_pulser.sv
// Debouncer: synchronizes a raw switch line, accepts a level change only
// after Settle consecutive stable cycles, and emits one-cycle press /
// release pulses on each accepted change.
//
// State is held in 'state' (state_t). A change of the synchronized input
// moves the FSM into a transitional state; any reversal there returns to
// the previous steady state with no pulse, and the next attempt restarts
// the counter at 0.
module debounce_pulser
   import debounce_pulser_pkg::*;
#(
   parameter int Size   = 8,
   parameter int Settle = 200
) (
   input  logic clock,
   input  logic reset,
   input  logic button_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   generate
      if (!settle_ok(Size, Settle)) begin : g_bad_settle
         $error("debounce_pulser: Settle=%0d out of range 1..2**%0d", Settle, Size);
      end
   endgenerate

   // Terminal count; Settle = 2**Size gives all-ones, so cnt never wraps.
   localparam logic [Size-1:0] CNT_LAST = Size'(Settle - 1);

   logic            s;
   state_t          state, state_next;
   logic [Size-1:0] cnt, cnt_next;
   logic            level_next, press_next, release_next;

   input_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (button_i),
      .q_o   (s)
   );

   // State, counter and registered outputs; reset discards any settle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= LOW;
         cnt       <= '0;
         level_o   <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         level_o   <= level_next;
         press_o   <= press_next;
         release_o <= release_next;
      end
   end

   // Next-state logic; pulses default low so they last exactly one cycle.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      level_next   = level_o;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state)
         LOW: begin
            if (s) begin
               state_next = TO_HIGH;
               cnt_next   = '0;
            end
         end
         TO_HIGH: begin
            if (!s) begin
               state_next = LOW;
            end else if (cnt == CNT_LAST) begin
               state_next = HIGH;
               level_next = 1'b1;
               press_next = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!s) begin
               state_next = TO_LOW;
               cnt_next   = '0;
            end
         end
         TO_LOW: begin
            if (s) begin
               state_next = HIGH;
            end else if (cnt == CNT_LAST) begin
               state_next   = LOW;
               level_next   = 1'b0;
               release_next = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = LOW;
         end
      endcase
   end

endmodule

// File: tb/tb_debounce_pulser.sv
// Bench for debounce_pulser: three instances (Size=3; Settle=4, 8, 1) share
// one stimulus stream. A reference model checks every cycle: the level
// flips once the two-cycle-delayed input has disagreed with it for
// Settle+1 consecutive edges, with a pulse on that edge.
module tb_debounce_pulser;

   localparam int N = 3;
   localparam int SETTLE [N] = '{4, 8, 1};

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic button = 1'b0;
   logic [N-1:0] level_w, press_w, release_w;

   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   bit chk_en = 1'b0;

   // model state
   bit m_d1 [N];
   bit m_d2 [N];
   bit m_level [N];
   bit m_press [N];
   bit m_rel [N];
   int m_run [N];

   // pulse logs
   int press_cnt [N];
   int rel_cnt [N];
   int press_edge [N];
   int rel_edge [N];

   always #5 clock = ~clock;

   debounce_pulser #(.Size(3), .Settle(4)) u_s4 (
      .clock(clock), .reset(reset), .button_i(button),
      .level_o(level_w[0]), .press_o(press_w[0]), .release_o(release_w[0]));
   debounce_pulser #(.Size(3), .Settle(8)) u_s8 (
      .clock(clock), .reset(reset), .button_i(button),
      .level_o(level_w[1]), .press_o(press_w[1]), .release_o(release_w[1]));
   debounce_pulser #(.Size(3), .Settle(1)) u_s1 (
      .clock(clock), .reset(reset), .button_i(button),
      .level_o(level_w[2]), .press_o(press_w[2]), .release_o(release_w[2]));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference model, advanced on every rising edge.
   always @(posedge clock) begin
      edge_n++;
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            m_d1[i] = 1'b0; m_d2[i] = 1'b0;
            m_level[i] = 1'b0; m_press[i] = 1'b0; m_rel[i] = 1'b0;
            m_run[i] = 0;
         end else begin
            m_press[i] = 1'b0;
            m_rel[i] = 1'b0;
            if (m_d2[i] != m_level[i]) begin
               m_run[i]++;
               if (m_run[i] == SETTLE[i] + 1) begin
                  m_level[i] = ~m_level[i];
                  if (m_level[i]) m_press[i] = 1'b1;
                  else m_rel[i] = 1'b1;
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = button;
         end
      end
   end

   // Compare DUT against model on the falling edge and log pulses.
   always @(negedge clock) begin
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("level[%0d]", i), int'(level_w[i]), int'(m_level[i]));
            check($sformatf("press[%0d]", i), int'(press_w[i]), int'(m_press[i]));
            check($sformatf("release[%0d]", i), int'(release_w[i]), int'(m_rel[i]));
            check($sformatf("exclusive[%0d]", i), int'(press_w[i] & release_w[i]), 0);
            if (press_w[i] === 1'b1) begin
               press_cnt[i]++;
               press_edge[i] = edge_n;
            end
            if (release_w[i] === 1'b1) begin
               rel_cnt[i]++;
               rel_edge[i] = edge_n;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      int e0;
      int pc0;
      int rc0;
      for (int i = 0; i < N; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0; press_edge[i] = -1; rel_edge[i] = -1;
      end

      // 1: reset two cycles, then quiet for 20 cycles
      reset = 1'b1; button = 1'b0;
      idle(2);
      reset = 1'b0;
      chk_en = 1'b1;
      idle(20);
      check("quiet_level", int'(level_w[0]), 0);
      check("quiet_press_cnt", press_cnt[0] + press_cnt[1] + press_cnt[2], 0);

      // 2 and 6: rising edge held; Settle 4/8/1 press at E6/E10/E3
      button = 1'b1; e0 = edge_n + 1;
      idle(15);
      check("rise_s4_edge", press_edge[0] - e0, 6);
      check("rise_s8_edge", press_edge[1] - e0, 10);
      check("rise_s1_edge", press_edge[2] - e0, 3);
      check("rise_s4_count", press_cnt[0], 1);
      check("rise_s8_count", press_cnt[1], 1);
      check("rise_s4_level", int'(level_w[0]), 1);
      check("rise_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 0);

      // 4: falling edge held; release at E6
      pc0 = press_cnt[0];
      button = 1'b0; e0 = edge_n + 1;
      idle(15);
      check("fall_s4_edge", rel_edge[0] - e0, 6);
      check("fall_s4_count", rel_cnt[0], 1);
      check("fall_no_press", press_cnt[0], pc0);
      check("fall_s4_level", int'(level_w[0]), 0);

      // 3: bounce 1,1,1,0,0,0 then 1 held; press at E12 only
      pc0 = press_cnt[0];
      button = 1'b1; e0 = edge_n + 1;
      idle(3);
      button = 1'b0;
      idle(3);
      button = 1'b1;
      idle(12);
      check("bounce_s4_edge", press_edge[0] - e0, 12);
      check("bounce_s4_count", press_cnt[0] - pc0, 1);
      check("bounce_s4_level", int'(level_w[0]), 1);

      // 5: reset at the edge where cnt=2 (E5); press restarts, lands at E12
      button = 1'b0;
      idle(15);
      pc0 = press_cnt[0];
      rc0 = rel_cnt[0];
      button = 1'b1; e0 = edge_n + 1;
      idle(5);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check("rst_mid_level", int'(level_w[0]), 0);
      check("rst_mid_no_press", press_cnt[0] - pc0, 0);
      idle(12);
      check("rst_mid_edge", press_edge[0] - e0, 12);
      check("rst_mid_count", press_cnt[0] - pc0, 1);
      check("rst_mid_no_release", rel_cnt[0], rc0);

      // randomized holds, glitches and occasional resets
      for (int k = 0; k < 600; k++) begin
         int hold;
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end
         button = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 16);
         idle(hold);
      end
      button = 1'b0;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
